// File: rtl/krypton_glyph_sequencer.sv
// ---------------------------------------------------------------------------
// krypton_glyph_sequencer
//
// Fetches one glyph row per character request from the character RAM and
// serialises it MSB-first into a 1-bit pixel stream. Host glyph uploads are
// forwarded to the RAM write port. A write is held back by one cycle when it
// targets the address the RAM is sampling for an in-flight read.
//
// Optional feature macro: KRYPTON_GLYPH_INVERT_EN
//   When defined, adds input i_chr_invert. It is captured with the request,
//   travels with the glyph through the buffer, and inverts the glyph row
//   (XOR with all ones) when the shifter loads it.
//
// Ports
//   i_sys_clk      : single clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_chr_valid    : character request valid
//   o_chr_ready    : request accepted when valid & ready
//   i_chr_code     : character code
//   i_chr_row      : glyph row within the character
//   i_chr_invert   : (KRYPTON_GLYPH_INVERT_EN only) invert this glyph row
//   o_pix_valid    : pixel valid
//   i_pix_ready    : pixel consumed when valid & ready
//   o_pix          : current pixel, MSB of the glyph row first
//   o_pix_last     : high on the final (LSB) pixel of a row
//   o_rom_rd_adr   : registered RAM read address {code,row}
//   i_rom_data     : RAM read data, one cycle after the address
//   i_host_wr_req  : host write request, held until acknowledged
//   i_host_adr     : host write address
//   i_host_data    : host write data
//   o_host_wr_ack  : one-cycle pulse, coincident with o_rom_wr_en
//   o_rom_wr_en    : registered RAM write enable
//   o_rom_wr_adr   : registered RAM write address
//   o_rom_wr_data  : registered RAM write data
//   o_busy         : fetch in progress, or buffer/shifter holds data
// ---------------------------------------------------------------------------
module krypton_glyph_sequencer #(
    parameter int CODE_WIDTH = 8,
    parameter int ROW_WIDTH  = 3,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst,
    input  logic                  i_chr_valid,
    output logic                  o_chr_ready,
    input  logic [CODE_WIDTH-1:0] i_chr_code,
    input  logic [ROW_WIDTH-1:0]  i_chr_row,
`ifdef KRYPTON_GLYPH_INVERT_EN
    input  logic                  i_chr_invert,
`endif
    output logic                  o_pix_valid,
    input  logic                  i_pix_ready,
    output logic                  o_pix,
    output logic                  o_pix_last,
    output logic [ADDR_WIDTH-1:0] o_rom_rd_adr,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    input  logic                  i_host_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_host_adr,
    input  logic [DATA_WIDTH-1:0] i_host_data,
    output logic                  o_host_wr_ack,
    output logic                  o_rom_wr_en,
    output logic [ADDR_WIDTH-1:0] o_rom_wr_adr,
    output logic [DATA_WIDTH-1:0] o_rom_wr_data,
    output logic                  o_busy
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_ADDR = 2'd1,
        F_DATA = 2'd2
    } fetch_state_e;

    fetch_state_e fetchState_q, fetchState_d;

    logic [ADDR_WIDTH-1:0] rdAdr_q,    rdAdr_d;
    logic [DATA_WIDTH-1:0] bufData_q,  bufData_d;
    logic                  bufValid_q, bufValid_d;
    logic [DATA_WIDTH-1:0] shReg_q,    shReg_d;
    logic [CNT_WIDTH-1:0]  shCnt_q,    shCnt_d;
    logic                  shValid_q,  shValid_d;
    logic                  wrEn_q,     wrEn_d;
    logic                  wrAck_q,    wrAck_d;
    logic [ADDR_WIDTH-1:0] wrAdr_q,    wrAdr_d;
    logic [DATA_WIDTH-1:0] wrData_q,   wrData_d;
`ifdef KRYPTON_GLYPH_INVERT_EN
    logic                  reqInv_q,   reqInv_d;
    logic                  bufInv_q,   bufInv_d;
`endif

    logic                  chrAccept;
    logic                  pixFire;
    logic                  lastFire;
    logic                  shLoad;
    logic                  wrIssue;
    logic [DATA_WIDTH-1:0] loadData;

    // Fetch FSM: a new request is only taken while idle with an empty glyph
    // buffer, so a fetched row always has somewhere to land. Ready is masked
    // by reset so nothing is accepted on a reset cycle.
    always_comb begin
        fetchState_d = fetchState_q;
        o_chr_ready  = 1'b0;
        chrAccept    = 1'b0;
        unique case (fetchState_q)
            F_IDLE: begin
                o_chr_ready = !i_rst && !bufValid_q;
                chrAccept   = i_chr_valid && o_chr_ready;
                if (chrAccept) begin
                    fetchState_d = F_ADDR;
                end
            end
            F_ADDR:  fetchState_d = F_DATA;
            F_DATA:  fetchState_d = F_IDLE;
            default: fetchState_d = F_IDLE;
        endcase
    end

    // Datapath next-state. The shifter reloads from the buffer either when it
    // is empty or on the very cycle its last pixel is consumed, which is what
    // keeps consecutive rows gap-free at one pixel per cycle.
    always_comb begin
        pixFire  = shValid_q && i_pix_ready;
        lastFire = pixFire && (shCnt_q == CNT_LAST);
        shLoad   = bufValid_q && (!shValid_q || lastFire);

`ifdef KRYPTON_GLYPH_INVERT_EN
        loadData = bufData_q ^ {DATA_WIDTH{bufInv_q}};
`else
        loadData = bufData_q;
`endif

        rdAdr_d = rdAdr_q;
        if (chrAccept) begin
            rdAdr_d = {i_chr_code, i_chr_row};
        end

        // The buffer cannot be loaded and drained in the same cycle: a fetch
        // is only started while the buffer is empty, so it is still empty
        // when the data arrives in F_DATA.
        bufData_d  = bufData_q;
        bufValid_d = bufValid_q;
        if (fetchState_q == F_DATA) begin
            bufData_d  = i_rom_data;
            bufValid_d = 1'b1;
        end else if (shLoad) begin
            bufValid_d = 1'b0;
        end

        shReg_d   = shReg_q;
        shCnt_d   = shCnt_q;
        shValid_d = shValid_q;
        if (shLoad) begin
            shReg_d   = loadData;
            shCnt_d   = '0;
            shValid_d = 1'b1;
        end else if (pixFire) begin
            shReg_d = {shReg_q[DATA_WIDTH-2:0], 1'b0};
            shCnt_d = shCnt_q + 1'b1;
            if (lastFire) begin
                shValid_d = 1'b0;
            end
        end

`ifdef KRYPTON_GLYPH_INVERT_EN
        reqInv_d = reqInv_q;
        bufInv_d = bufInv_q;
        if (chrAccept) begin
            reqInv_d = i_chr_invert;
        end
        if (fetchState_q == F_DATA) begin
            bufInv_d = reqInv_q;
        end
`endif
    end

    // Host write arbitration. The ack of the previous cycle blocks a reissue
    // so a held request produces exactly one write. The only conflict is a
    // write to the address the RAM is sampling during F_ADDR; it is delayed
    // by one cycle so the read sees the pre-write contents.
    always_comb begin
        wrIssue  = i_host_wr_req && !wrAck_q &&
                   !((fetchState_q == F_ADDR) && (rdAdr_q == i_host_adr));
        wrEn_d   = wrIssue;
        wrAck_d  = wrIssue;
        wrAdr_d  = wrIssue ? i_host_adr  : wrAdr_q;
        wrData_d = wrIssue ? i_host_data : wrData_q;
    end

    // State registers with synchronous reset; reset discards any in-flight
    // fetch, buffered row, shifting row and pending write.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            fetchState_q <= F_IDLE;
            rdAdr_q      <= '0;
            bufData_q    <= '0;
            bufValid_q   <= 1'b0;
            shReg_q      <= '0;
            shCnt_q      <= '0;
            shValid_q    <= 1'b0;
            wrEn_q       <= 1'b0;
            wrAck_q      <= 1'b0;
            wrAdr_q      <= '0;
            wrData_q     <= '0;
`ifdef KRYPTON_GLYPH_INVERT_EN
            reqInv_q     <= 1'b0;
            bufInv_q     <= 1'b0;
`endif
        end else begin
            fetchState_q <= fetchState_d;
            rdAdr_q      <= rdAdr_d;
            bufData_q    <= bufData_d;
            bufValid_q   <= bufValid_d;
            shReg_q      <= shReg_d;
            shCnt_q      <= shCnt_d;
            shValid_q    <= shValid_d;
            wrEn_q       <= wrEn_d;
            wrAck_q      <= wrAck_d;
            wrAdr_q      <= wrAdr_d;
            wrData_q     <= wrData_d;
`ifdef KRYPTON_GLYPH_INVERT_EN
            reqInv_q     <= reqInv_d;
            bufInv_q     <= bufInv_d;
`endif
        end
    end

    // A fully shifted row leaves zeros behind, so o_pix is also 0 while the
    // shifter is empty.
    assign o_pix_valid   = shValid_q;
    assign o_pix         = shReg_q[DATA_WIDTH-1];
    assign o_pix_last    = shValid_q && (shCnt_q == CNT_LAST);
    assign o_rom_rd_adr  = rdAdr_q;
    assign o_host_wr_ack = wrAck_q;
    assign o_rom_wr_en   = wrEn_q;
    assign o_rom_wr_adr  = wrAdr_q;
    assign o_rom_wr_data = wrData_q;
    assign o_busy        = (fetchState_q != F_IDLE) || bufValid_q || shValid_q;

endmodule

// File: tb/tb_krypton_glyph_sequencer.sv
// ---------------------------------------------------------------------------
// tb_krypton_glyph_sequencer
//
// Self-checking bench for krypton_glyph_sequencer. A read-first character RAM
// sits on the DUT's RAM ports. The reference model is a plain image of what
// the RAM should contain (updated when the bench's own host writes are
// acknowledged) and a queue of expected pixels built from each accepted
// request. Inputs are driven 1 time unit after the rising edge, outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_krypton_glyph_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chrValid = 1'b0;
    logic        chrReady;
    logic [7:0]  chrCode = '0;
    logic [2:0]  chrRow = '0;
    logic        chrInvert = 1'b0;
    logic        pixValid;
    logic        pix;
    logic        pixLast;
    logic        readyCtl = 1'b1;
    logic        randMode = 1'b0;
    logic        randBit = 1'b1;
    logic        pixReady;
    logic [10:0] rdAdr;
    logic [7:0]  romData = '0;
    logic        hostReq = 1'b0;
    logic [10:0] hostAdr = '0;
    logic [7:0]  hostData = '0;
    logic        hostAck;
    logic        wrEn;
    logic [10:0] wrAdr;
    logic [7:0]  wrData;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastAcceptCyc = 0;
    int lastAckCyc = 0;

    logic [7:0] mem    [0:2047];
    logic [7:0] refMem [0:2047];
    logic       ramInit = 1'b0;

    logic expQ[$];
    logic expLastQ[$];
    logic gotQ[$];
    logic gotLastQ[$];
    int   gotCycQ[$];

    assign pixReady = randMode ? randBit : readyCtl;

    krypton_glyph_sequencer dut (
        .i_sys_clk     (clk),
        .i_rst         (rst),
        .i_chr_valid   (chrValid),
        .o_chr_ready   (chrReady),
        .i_chr_code    (chrCode),
        .i_chr_row     (chrRow),
`ifdef KRYPTON_GLYPH_INVERT_EN
        .i_chr_invert  (chrInvert),
`endif
        .o_pix_valid   (pixValid),
        .i_pix_ready   (pixReady),
        .o_pix         (pix),
        .o_pix_last    (pixLast),
        .o_rom_rd_adr  (rdAdr),
        .i_rom_data    (romData),
        .i_host_wr_req (hostReq),
        .i_host_adr    (hostAdr),
        .i_host_data   (hostData),
        .o_host_wr_ack (hostAck),
        .o_rom_wr_en   (wrEn),
        .o_rom_wr_adr  (wrAdr),
        .o_rom_wr_data (wrData),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] initByte(input int a);
        return 8'((a * 37 + 11) ^ (a >> 3));
    endfunction

    // Cycle counter: value k is seen throughout the cycle after edge k.
    always @(posedge clk) cyc <= cyc + 1;

    // Character RAM: synchronous read-first, one-cycle latency.
    always @(posedge clk) begin
        if (!ramInit) begin
            for (int i = 0; i < 2048; i++) mem[i] <= initByte(i);
            ramInit <= 1'b1;
        end else begin
            romData <= mem[rdAdr];
            if (wrEn) mem[wrAdr] <= wrData;
        end
    end

    // Random pixel-ready source, ~75% duty.
    always @(posedge clk) randBit <= ($urandom_range(0, 3) != 0);

    // Pixel collector: a pixel shown with ready high at the falling edge is
    // consumed at the next rising edge.
    always @(negedge clk) begin
        if (!rst && pixValid && pixReady) begin
            gotQ.push_back(pix);
            gotLastQ.push_back(pixLast);
            gotCycQ.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request until accepted; on acceptance the expected row is
    // taken from the RAM image and queued MSB first.
    task automatic send_req(input logic [7:0] code, input logic [2:0] row, input logic inv);
        int n;
        logic accepted;
        logic [7:0] rowBits;
        logic [10:0] a;
        chrValid = 1'b1;
        chrCode = code;
        chrRow = row;
        chrInvert = inv;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 200) begin
            @(negedge clk);
            if (chrReady) begin
                accepted = 1'b1;
                lastAcceptCyc = cyc;
                a = {code, row};
                rowBits = refMem[a];
`ifdef KRYPTON_GLYPH_INVERT_EN
                if (inv) rowBits = ~rowBits;
`endif
                for (int b = 7; b >= 0; b--) begin
                    expQ.push_back(rowBits[b]);
                    expLastQ.push_back(b == 0);
                end
            end
            tick();
            n++;
        end
        chrValid = 1'b0;
        chrInvert = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("[TB] FAIL req_accept code %0h row %0d got no accept, required accept within 200 cycles", code, row);
        end
    endtask

    task automatic host_write(input logic [10:0] a, input logic [7:0] d, input int expLat, input string name);
        int k;
        int n;
        logic got;
        hostReq = 1'b1;
        hostAdr = a;
        hostData = d;
        k = cyc;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (hostAck) got = 1'b1;
            else n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL %s ack timeout: got none, required ack within 20 cycles", name);
        end else begin
            checks++;
            if (cyc - k != expLat) begin
                errors++;
                $display("[TB] FAIL %s latency got %0d required %0d", name, cyc - k, expLat);
            end
            checks++;
            if (wrEn !== 1'b1 || wrAdr !== a || wrData !== d) begin
                errors++;
                $display("[TB] FAIL %s port got en %b adr %h data %h required en 1 adr %h data %h",
                         name, wrEn, wrAdr, wrData, a, d);
            end
            lastAckCyc = cyc;
        end
        tick();
        hostReq = 1'b0;
        refMem[a] = d;
    endtask

    // Waits (bounded) until every expected pixel has been collected, then a
    // few more cycles so any surplus pixels show up too.
    task automatic wait_drain();
        int n;
        n = 0;
        while (gotQ.size() < expQ.size() && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hostReq = 1'b1;
        hostAdr = 11'h400;
        hostData = 8'h5A;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (chrReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_chr_ready got %b required 0", chrReady); end
        checks++; if (pixValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_valid got %b required 0", pixValid); end
        checks++; if (pix !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix got %b required 0", pix); end
        checks++; if (pixLast !== 1'b0) begin errors++; $display("[TB] FAIL rst_pix_last got %b required 0", pixLast); end
        checks++; if (rdAdr !== 11'h0) begin errors++; $display("[TB] FAIL rst_rd_adr got %h required 0", rdAdr); end
        checks++; if (hostAck !== 1'b0) begin errors++; $display("[TB] FAIL rst_host_ack got %b required 0", hostAck); end
        checks++; if (wrEn !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr_en got %b required 0", wrEn); end
        checks++; if (wrAdr !== 11'h0 || wrData !== 8'h0) begin errors++; $display("[TB] FAIL rst_wr_adr_data got %h/%h required 0/0", wrAdr, wrData); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b required 0", busy); end
        tick();
        rst = 1'b0;
        // The request held through reset is arbitrated as soon as reset lifts.
        host_write(11'h400, 8'h5A, 1, "post_reset_write");
        @(negedge clk);
        checks++; if (chrReady !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready_busy got %b/%b required 1/0", chrReady, busy); end
        tick();
    endtask

    task automatic test_single_fetch();
        int base;
        base = expQ.size();
        host_write(11'h20B, 8'hA5, 1, "preload_20B");
        send_req(8'h41, 3'd3, 1'b0);
        @(negedge clk);
        checks++; if (rdAdr !== 11'h20B) begin errors++; $display("[TB] FAIL single_rd_adr got %h required 20b", rdAdr); end
        wait_drain();
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL single_count got %0d required %0d", gotQ.size(), expQ.size()); end
        if (gotCycQ.size() > base) begin
            checks++;
            if (gotCycQ[base] - lastAcceptCyc != 4) begin
                errors++;
                $display("[TB] FAIL single_latency got %0d required 4 (cycle index distance)", gotCycQ[base] - lastAcceptCyc);
            end
        end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL single_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int acc [4];
        base = expQ.size();
        for (int r = 0; r < 4; r++) begin
            send_req(8'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
            acc[r] = lastAcceptCyc;
        end
        wait_drain();
        checks++;
        if (acc[2] - acc[1] != 8 || acc[3] - acc[2] != 8) begin
            errors++;
            $display("[TB] FAIL b2b_accept_spacing got %0d,%0d required 8,8", acc[2] - acc[1], acc[3] - acc[2]);
        end
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL b2b_count got %0d required %0d", gotQ.size(), expQ.size()); end
        else begin
            checks++;
            if (gotCycQ[base + 31] - gotCycQ[base] != 31) begin
                errors++;
                $display("[TB] FAIL b2b_contiguous got span %0d required 31", gotCycQ[base + 31] - gotCycQ[base]);
            end
        end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL b2b_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        int n;
        base = expQ.size();
        send_req(8'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
        send_req(8'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
        n = 0;
        while (gotQ.size() < base + 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tick();
        readyCtl = 1'b0;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            checks++;
            if (pixValid !== 1'b1 || pix !== expQ[base + 3] || pixLast !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d got v%b p%b l%b required v1 p%b l0", s, pixValid, pix, pixLast, expQ[base + 3]);
            end
            checks++;
            if (chrReady !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_chr_ready cycle %0d got %b required 0", s, chrReady);
            end
        end
        tick();
        readyCtl = 1'b1;
        wait_drain();
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL stall_count got %0d required %0d", gotQ.size(), expQ.size()); end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL stall_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask

    task automatic test_collision();
        int base;
        base = expQ.size();
        // send_req returns during the F_ADDR cycle of this fetch.
        send_req(8'h41, 3'd3, 1'b0);
        host_write(11'h20B, 8'h3C, 2, "collide_write");
        send_req(8'h41, 3'd3, 1'b0);
        wait_drain();
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL collide_count got %0d required %0d", gotQ.size(), expQ.size()); end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL collide_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask

    task automatic test_host_back_to_back();
        int base;
        int firstAck;
        base = expQ.size();
        host_write(11'h5F0, 8'h11, 1, "b2b_write0");
        firstAck = lastAckCyc;
        host_write(11'h5F1, 8'h22, 1, "b2b_write1");
        checks++;
        if (lastAckCyc - firstAck != 2) begin
            errors++;
            $display("[TB] FAIL host_b2b_spacing got %0d required 2", lastAckCyc - firstAck);
        end
        send_req(8'hBE, 3'd0, 1'b0);
        send_req(8'hBE, 3'd1, 1'b0);
        wait_drain();
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL host_b2b_count got %0d required %0d", gotQ.size(), expQ.size()); end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL host_b2b_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int base;
        base = expQ.size();
        send_req(8'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
        repeat (5) tick();
        // Second request: accepted once the first row is in the shifter.
        chrValid = 1'b1;
        chrCode = 8'($urandom_range(0, 127));
        chrRow = 3'($urandom_range(0, 7));
        @(negedge clk);
        checks++; if (chrReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_second_ready got %b required 1", chrReady); end
        tick();
        chrValid = 1'b0;
        tick();
        // Now in F_DATA for the second fetch with four pixels of row one left.
        rst = 1'b1;
        checks++;
        if (gotQ.size() != base + 4) begin errors++; $display("[TB] FAIL mid_consumed got %0d required 4", gotQ.size() - base); end
        tick();
        @(negedge clk);
        checks++;
        if (chrReady !== 1'b0 || pixValid !== 1'b0 || pix !== 1'b0 || pixLast !== 1'b0 || rdAdr !== 11'h0 ||
            hostAck !== 1'b0 || wrEn !== 1'b0 || wrAdr !== 11'h0 || wrData !== 8'h0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs got rdy%b v%b p%b l%b ra%h ack%b we%b wa%h wd%h busy%b required all 0",
                     chrReady, pixValid, pix, pixLast, rdAdr, hostAck, wrEn, wrAdr, wrData, busy);
        end
        while (expQ.size() > gotQ.size()) begin
            void'(expQ.pop_back());
            void'(expLastQ.pop_back());
        end
        tick();
        rst = 1'b0;
        send_req(8'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
        wait_drain();
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL mid_count got %0d required %0d", gotQ.size(), expQ.size()); end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL mid_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask

`ifdef KRYPTON_GLYPH_INVERT_EN
    task automatic test_invert();
        int base;
        base = expQ.size();
        host_write(11'h20B, 8'hA5, 1, "inv_preload");
        send_req(8'h41, 3'd3, 1'b1);
        send_req(8'h41, 3'd3, 1'b0);
        wait_drain();
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL inv_count got %0d required %0d", gotQ.size(), expQ.size()); end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL inv_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int base;
        logic [10:0] written[$];
        logic [10:0] wa;
        base = expQ.size();
        randMode = 1'b1;
        fork
            begin
                for (int r = 0; r < 24; r++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send_req(8'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'b0);
                end
            end
            begin
                for (int w = 0; w < 6; w++) begin
                    repeat ($urandom_range(1, 12)) tick();
                    wa = 11'h400 + 11'($urandom_range(0, 1023));
                    written.push_back(wa);
                    host_write(wa, 8'($urandom), 1, "rand_write");
                end
            end
        join
        wait_drain();
        randMode = 1'b0;
        for (int w = 0; w < 3; w++) begin
            wa = written[w];
            send_req(wa[10:3], wa[2:0], 1'b0);
        end
        wait_drain();
        checks++;
        if (gotQ.size() != expQ.size()) begin errors++; $display("[TB] FAIL rand_count got %0d required %0d", gotQ.size(), expQ.size()); end
        for (int i = base; i < expQ.size() && i < gotQ.size(); i++) begin
            checks++;
            if (gotQ[i] !== expQ[i] || gotLastQ[i] !== expLastQ[i]) begin
                errors++;
                $display("[TB] FAIL rand_pixel idx %0d got %b/%b required %b/%b", i - base, gotQ[i], gotLastQ[i], expQ[i], expLastQ[i]);
            end
        end
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) refMem[i] = initByte(i);
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_backpressure();
        test_collision();
        test_host_back_to_back();
        test_reset_midstream();
`ifdef KRYPTON_GLYPH_INVERT_EN
        test_invert();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/krypton_glyph_sequencer.md
# krypton_glyph_sequencer

Sequences character-glyph fetches from the 2048x8 character RAM and serialises each glyph row into a 1-bit pixel stream for the text-mode scanout. It also forwards host glyph uploads to the RAM write port, holding any write that would collide with an in-flight read. The block sits between the text-attribute pipeline (character requests), the character RAM (synchronous read, 1-cycle latency), and the pixel mixer.

## Interface
- CODE_WIDTH, 8, character code bits
- ROW_WIDTH, 3, glyph row bits (8 rows per glyph)
- ADDR_WIDTH, 11, RAM address = {code, row}; must equal CODE_WIDTH+ROW_WIDTH
- DATA_WIDTH, 8, pixels per glyph row
- i_sys_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_chr_valid  in  1  character request valid
- o_chr_ready  out  1  request accepted when valid&ready
- i_chr_code  in  CODE_WIDTH  character code
- i_chr_row  in  ROW_WIDTH  glyph row
- o_pix_valid  out  1  pixel valid
- i_pix_ready  in  1  pixel consumed when valid&ready
- o_pix  out  1  pixel, MSB of glyph row first
- o_pix_last  out  1  high on final (LSB) pixel of a row
- o_rom_rd_adr  out  ADDR_WIDTH  RAM read address, registered
- i_rom_data  in  DATA_WIDTH  RAM read data
- i_host_wr_req  in  1  host write request, held until ack
- i_host_adr  in  ADDR_WIDTH  host write address
- i_host_data  in  DATA_WIDTH  host write data
- o_host_wr_ack  out  1  one-cycle pulse when write issued
- o_rom_wr_en  out  1  RAM write enable, registered
- o_rom_wr_adr  out  ADDR_WIDTH  RAM write address, registered
- o_rom_wr_data  out  DATA_WIDTH  RAM write data, registered
- o_busy  out  1  fetch not idle, or buffer or shifter holds data

## Operation
- Fetch FSM: F_IDLE -> F_ADDR -> F_DATA -> F_IDLE.
  - F_IDLE: o_chr_ready = !i_rst & glyph buffer empty. On accept: o_rom_rd_adr <= {code,row}; go F_ADDR.
  - F_ADDR: RAM samples address; go F_DATA.
  - F_DATA: buffer <= i_rom_data, buffer valid <= 1; go F_IDLE.
- Glyph buffer: one entry. Shifter loads from the buffer when the shifter is empty, or when the last pixel is consumed that cycle; a load clears buffer valid.
- Shifter: 8-bit register plus 3-bit count. The pixel is shifted out on valid&ready. o_pix_last = (count==7). The shifter empties after the 8th consumption unless a reload occurs in the same cycle.
- Backpressure: with i_pix_ready low, the pixel and count hold. The buffer may fill; o_chr_ready then stays low.
- Host write arbitration:
  - A write is issued when i_host_wr_req=1, o_host_wr_ack was 0 last cycle, and NOT (fetch state in {F_ADDR} with o_rom_rd_adr == i_host_adr).
  - Issue: o_rom_wr_en/adr/data registered next edge, o_host_wr_ack pulses the same cycle as o_rom_wr_en.
  - The host drops the request or presents the next write after the ack. Back-to-back writes issue every 2 cycles.
- Same-cycle write issue and character accept to the same address is legal. The write lands at the same edge the RAM samples the read, so the read returns old data. Character accept is never stalled by host writes.
- Reset: FSM to F_IDLE; buffer and shifter empty. All outputs are 0: o_chr_ready, o_pix_valid, o_pix, o_pix_last, o_rom_rd_adr, o_host_wr_ack, o_rom_wr_en/adr/data, o_busy. An in-flight fetch or pending write is discarded. A held i_host_wr_req is re-arbitrated after reset.

## Timing
- Accept at edge T -> buffer valid after T+2 -> shifter loads at T+3 if empty -> first o_pix_valid in cycle after T+3 (3-cycle request-to-pixel latency).
- Sustained throughput is 1 pixel/cycle: the next request is accepted as soon as the buffer empties (at shifter load), and fetch (3 cycles) is shorter than a row (8 cycles).
- Host write: request seen at edge T -> o_rom_wr_en and o_host_wr_ack high in cycle after T; a collision adds 1 cycle.

## Configuration
- KRYPTON_GLYPH_INVERT_EN defined: adds port i_chr_invert (in, 1). It is captured with the request, carried through the buffer, and the glyph is XORed with 0xFF on shifter load.
- Undefined: port absent; pixels are RAM data unmodified.

## Test plan
- Code 0x41, row 3, RAM[0x20B]=0xA5, i_pix_ready=1 -> o_rom_rd_adr=0x20B; 3 cycles later pixels 1,0,1,0,0,1,0,1; o_pix_last on the 8th.
- Four requests back-to-back with ready=1 -> 32 contiguous pixel cycles with no gap; o_chr_ready low while the buffer is full.
- i_pix_ready low for 10 cycles mid-row -> o_pix held stable; o_chr_ready low once the buffer fills; the stream resumes exactly where it stopped.
- Host write adr=0x20B, data=0x3C while a fetch of 0x20B is in F_ADDR -> write held 1 cycle; the fetch returns the old data 0xA5; a subsequent fetch returns 0x3C.
- i_rst asserted during F_DATA with 4 pixels remaining -> next cycle all outputs 0, o_busy 0; the first request after reset is accepted and streams correctly.
- With KRYPTON_GLYPH_INVERT_EN, i_chr_invert=1, data 0xA5 -> pixels 0,1,0,1,1,0,1,0.
